// File: rtl/clk_div_gen_pkg.sv
// Shared types and helpers for the clk_div_gen clock generator.
// The CPU source mode encoding lives here so the top and the bench agree on it.
package clk_div_gen_pkg;

  typedef enum logic [1:0] {
    MODE_FAST = 2'd0,
    MODE_SLOW = 2'd1,
    MODE_CH   = 2'd2,
    MODE_STEP = 2'd3
  } mode_e;

  // Mask of the low 'tap' bits of the free-running counter; tap=0 gives 0 (tick every cycle).
  function automatic logic [63:0] tap_mask(input int tap);
    tap_mask = (64'd1 << tap) - 64'd1;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One runtime-programmable divider channel: divisor register, counter, tick and 50% square wave.
// A write reloads the divisor and restarts the count, taking priority over a coinciding tick.
module clk_div_ch #(
  parameter int               DIV_W   = 16,
  parameter logic [DIV_W-1:0] DIV_RST = 16'd49
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_div,
  output logic             tick,
  output logic             ch_clk
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             ch_clk_q, ch_clk_d;

  assign tick   = (cnt_q == div_q);
  assign ch_clk = ch_clk_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    div_d    = div_q;
    cnt_d    = cnt_q + 1'b1;
    ch_clk_d = ch_clk_q;
    if (wr_en) begin
      div_d = wr_div;
      cnt_d = '0;
    end else if (tick) begin
      cnt_d    = '0;
      ch_clk_d = ~ch_clk_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the divisor register is reset to DIV_RST rather than left unreset, so each
      // channel runs at a known rate straight out of reset.
      div_q    <= DIV_RST;
      cnt_q    <= '0;
      ch_clk_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      ch_clk_q <= ch_clk_d;
    end
  end

endmodule

// File: rtl/clk_div_gen.sv
// Free-running divider, NUM_CH programmable channels and a glitch-free CPU clock selector.
// Optional single-step source in mode 3 is built only when CLK_DIV_GEN_STEP_EN is defined.
module clk_div_gen
  import clk_div_gen_pkg::*;
#(
  parameter int               CNT_W    = 32,
  parameter int               NUM_CH   = 4,
  parameter int               DIV_W    = 16,
  parameter logic [DIV_W-1:0] DIV_RST  = 16'd49,
  parameter int               FAST_TAP = 1,
  parameter int               SLOW_TAP = 24,
  localparam int              CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [CH_W-1:0]   cpu_ch,
  input  logic              step,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DIV_W-1:0]  wr_div,
  output logic [CNT_W-1:0]  clkdiv,
  output logic [NUM_CH-1:0] ch_tick,
  output logic [NUM_CH-1:0] ch_clk,
  output logic              cpu_clk,
  output logic              cpu_ce
);

  localparam logic [CNT_W-1:0] FAST_MASK = CNT_W'(tap_mask(FAST_TAP));
  localparam logic [CNT_W-1:0] SLOW_MASK = CNT_W'(tap_mask(SLOW_TAP));

  logic [CNT_W-1:0] clkdiv_q, clkdiv_d;
  mode_e            mode_q, mode_d;
  logic [CH_W-1:0]  cpu_ch_q, cpu_ch_d;
  logic             cpu_clk_q, cpu_clk_d;
  logic             cpu_ce_q, cpu_ce_d;
  logic             fast_tick, slow_tick, chan_tick, step_tick, src_tick;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_ch #(
      .DIV_W  (DIV_W),
      .DIV_RST(DIV_RST)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_en (wr_en && (wr_ch == CH_W'(i))),
      .wr_div(wr_div),
      .tick  (ch_tick[i]),
      .ch_clk(ch_clk[i])
    );
  end

  assign fast_tick = ((clkdiv_q & FAST_MASK) == FAST_MASK);
  assign slow_tick = ((clkdiv_q & SLOW_MASK) == SLOW_MASK);
  assign chan_tick = (int'(cpu_ch_q) < NUM_CH) ? ch_tick[cpu_ch_q] : 1'b0;

`ifdef CLK_DIV_GEN_STEP_EN
  logic [2:0] step_sh_q, step_sh_d;
  logic       step_rise;

  always_comb step_sh_d = {step_sh_q[1:0], step};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_sh_q <= '0;
    else        step_sh_q <= step_sh_d;
  end

  // Rising edges seen while cpu_clk is high are absorbed by the forced falling tick.
  assign step_rise = step_sh_q[1] & ~step_sh_q[2];
  assign step_tick = cpu_clk_q | step_rise;
`else
  logic unused_step;
  assign unused_step = step;
  assign step_tick   = fast_tick;
`endif

  always_comb begin
    src_tick = fast_tick;
    case (mode_q)
      MODE_SLOW: src_tick = slow_tick;
      MODE_CH:   src_tick = chan_tick;
      MODE_STEP: src_tick = step_tick;
      default:   src_tick = fast_tick;
    endcase

    clkdiv_d  = clkdiv_q + 1'b1;
    cpu_clk_d = cpu_clk_q ^ src_tick;
    cpu_ce_d  = src_tick & ~cpu_clk_q;

    // Source selection only moves on a falling toggle, so no phase is ever cut short.
    mode_d   = mode_q;
    cpu_ch_d = cpu_ch_q;
    if (src_tick && cpu_clk_q) begin
      mode_d   = mode_e'(mode);
      cpu_ch_d = cpu_ch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clkdiv_q  <= '0;
      mode_q    <= MODE_FAST;
      cpu_ch_q  <= '0;
      cpu_clk_q <= 1'b0;
      cpu_ce_q  <= 1'b0;
    end else begin
      clkdiv_q  <= clkdiv_d;
      mode_q    <= mode_d;
      cpu_ch_q  <= cpu_ch_d;
      cpu_clk_q <= cpu_clk_d;
      cpu_ce_q  <= cpu_ce_d;
    end
  end

  assign clkdiv  = clkdiv_q;
  assign cpu_clk = cpu_clk_q;
  assign cpu_ce  = cpu_ce_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen with hand-computed expectations indexed by cycle after reset.
// Cycle n means the state sampled 1 time unit after the n-th rising edge following reset release.
module tb_clk_div_gen;

  localparam int CNT_W  = 32;
  localparam int NUM_CH = 4;
  localparam int DIV_W  = 16;
  localparam int CH_W   = 2;

  logic              clk    = 1'b0;
  logic              rst_n  = 1'b1;
  logic [1:0]        mode   = 2'd0;
  logic [CH_W-1:0]   cpu_ch = '0;
  logic              step   = 1'b0;
  logic              wr_en  = 1'b0;
  logic [CH_W-1:0]   wr_ch  = '0;
  logic [DIV_W-1:0]  wr_div = '0;
  logic [CNT_W-1:0]  clkdiv;
  logic [NUM_CH-1:0] ch_tick;
  logic [NUM_CH-1:0] ch_clk;
  logic              cpu_clk;
  logic              cpu_ce;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  clk_div_gen u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .mode   (mode),
    .cpu_ch (cpu_ch),
    .step   (step),
    .wr_en  (wr_en),
    .wr_ch  (wr_ch),
    .wr_div (wr_div),
    .clkdiv (clkdiv),
    .ch_tick(ch_tick),
    .ch_clk (ch_clk),
    .cpu_clk(cpu_clk),
    .cpu_ce (cpu_ce)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Called 1 unit after an edge: asserts reset mid-cycle, checks the immediate clear, releases.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_clkdiv", clkdiv, 0);
    check("rst_cpu_clk", cpu_clk, 0);
    check("rst_cpu_ce", cpu_ce, 0);
    check("rst_ch_tick", ch_tick, 0);
    check("rst_ch_clk", ch_clk, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  // Mode 0 with FAST_TAP=1 and reset divisors of 49 on every channel.
  task automatic run_from_reset(input int ncyc);
    for (int n = 1; n <= ncyc; n++) begin
      adv();
      check("clkdiv", clkdiv, n);
      check("cpu_clk_eq_bit1", cpu_clk, (n >> 1) & 1);
      check("cpu_ce", cpu_ce, (n % 4) == 2);
      check("rst_div_tick", ch_tick, (n == 49) ? 4'hF : 4'h0);
      check("rst_div_clk", ch_clk, (n >= 50) ? 4'hF : 4'h0);
    end
  endtask

  // ch1 div=9, mode 2 from cycle 0; mode 0 requested at cycle 31 while cpu_clk is high.
  function automatic logic t4_cpu(input int n);
    if (n >= 41) return ((n >> 1) & 1) == 1;
    return (n == 2 || n == 3) || (n >= 11 && n <= 20) || (n >= 31 && n <= 40);
  endfunction

  function automatic logic t4_ce(input int n);
    return (n == 2) || (n == 11) || (n == 31) || (n >= 42 && (n % 4) == 2);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk);
    #1;

    // Reset, then legacy mode 0 behaviour and reset divisors.
    do_reset();
    run_from_reset(64);

    // ch2 div=3 written at cycle 64; other channels keep counting toward 49.
    wr_en = 1'b1; wr_ch = 2'd2; wr_div = 16'd3;
    for (int m = 0; m < 16; m++) begin
      adv();
      wr_en = 1'b0;
      check("t2_ch_tick", ch_tick, ((m % 4) == 3) ? 4'b0100 : 4'b0000);
      check("t2_ch_clk", ch_clk, {1'b1, (((m / 4) % 2) == 0) ? 1'b1 : 1'b0, 2'b11});
    end

    // ch0 div=3 at cycle 80, then rewrite div=2 exactly on its tick at cycle 84.
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd3;
    for (int k = 1; k <= 4; k++) begin
      adv();
      wr_en = 1'b0;
      check("t3_tick0_pre", ch_tick[0], k == 4);
      check("t3_clk0_pre", ch_clk[0], 1);
    end
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd2;
    for (int k = 1; k <= 4; k++) begin
      adv();
      wr_en = 1'b0;
      check("t3_tick0_post", ch_tick[0], k == 3);
      check("t3_clk0_post", ch_clk[0], k != 4);
    end

    // Mode switch from channel source to fast tap while cpu_clk is high.
    do_reset();
    wr_en = 1'b1; wr_ch = 2'd1; wr_div = 16'd9; mode = 2'd2; cpu_ch = 2'd1;
    for (int n = 1; n <= 56; n++) begin
      adv();
      wr_en = 1'b0;
      check("t4_cpu_clk", cpu_clk, t4_cpu(n));
      check("t4_cpu_ce", cpu_ce, t4_ce(n));
      check("t4_ch_tick1", ch_tick[1], (n >= 10) && ((n % 10) == 0));
      if (n == 31) mode = 2'd0;
    end

    // Mode 3 requested at cycle 56 (cpu_clk low): takes effect after the next falling toggle.
    mode = 2'd3;
`ifdef CLK_DIV_GEN_STEP_EN
    for (int n = 57; n <= 112; n++) begin
      adv();
      check("t5_cpu_clk", cpu_clk, n == 58 || n == 59 || n == 67 || n == 87 || n == 107);
      check("t5_cpu_ce", cpu_ce, n == 58 || n == 67 || n == 87 || n == 107);
      step = (n == 64 || n == 84 || n == 104);
    end
`else
    for (int n = 57; n <= 72; n++) begin
      adv();
      check("t5_cpu_clk", cpu_clk, (n >> 1) & 1);
      check("t5_cpu_ce", cpu_ce, (n % 4) == 2);
      step = n[0];
    end
`endif

    // Reprogram ch3, bring cpu_clk high, then reset mid-run.
    step  = 1'b0;
    wr_en = 1'b1; wr_ch = 2'd3; wr_div = 16'd2;
    adv();
    wr_en = 1'b0;
`ifdef CLK_DIV_GEN_STEP_EN
    step = 1'b1;
    adv();
    step = 1'b0;
    adv();
    adv();
`else
    while ((cyc % 4) != 2) adv();
`endif
    check("t6_pre_cpu_clk", cpu_clk, 1);
    mode = 2'd0;
    do_reset();
    run_from_reset(52);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
